// File: rtl/xled_ctrl.sv
//==============================================================================
// xled_ctrl : memory-mapped LED controller with optional hardware blink engine
// Optional feature macro: LED_BLINK_EN (blink engine, BLINK_MASK, PERIOD, STATUS)
// Revision  : 1.0
//==============================================================================
`default_nettype none

module xled_ctrl #(
  parameter int N_LEDS = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [N_LEDS-1:0] led
);

  logic              wr;
  logic              rd;
  logic [N_LEDS-1:0] led_out;
  logic [N_LEDS-1:0] led_nxt;
  logic [DATA_W-1:0] rdata;

  assign wr = sel & we;
  assign rd = sel & ~we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else if (wr && addr == 2'd0) begin
      led_out <= data_in[N_LEDS-1:0];
    end
  end

`ifdef LED_BLINK_EN
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } blink_state_t;

  blink_state_t      state;
  logic [N_LEDS-1:0] blink_mask;
  logic [31:0]       period;
  logic [31:0]       cnt;
  logic              phase;

  // Run/stop is fully determined by PERIOD; no separate state storage.
  always_comb begin
    state = ST_STOP;
    if (period != 32'd0) begin
      state = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_mask <= '0;
      period     <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
    end else begin
      if (wr && addr == 2'd1) begin
        blink_mask <= data_in[N_LEDS-1:0];
      end
      // A PERIOD write restarts the count and suppresses any terminal toggle.
      if (wr && addr == 2'd2) begin
        period <= data_in[31:0];
        cnt    <= '0;
      end else if (state == ST_STOP) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == period - 32'd1) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  always_comb begin
    led_nxt = led_out ^ (blink_mask & {N_LEDS{phase}});
    rdata   = '0;
    case (addr)
      2'd0:    rdata[N_LEDS-1:0] = led_out;
      2'd1:    rdata[N_LEDS-1:0] = blink_mask;
      2'd2:    rdata[31:0]       = period;
      default: rdata[0]          = phase;
    endcase
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^data_in;

  always_comb begin
    led_nxt = led_out;
    rdata   = '0;
    if (addr == 2'd0) begin
      rdata[N_LEDS-1:0] = led_out;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      led      <= '0;
    end else begin
      led <= led_nxt;
      if (rd) begin
        data_out <= rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/xled_ctrl.md
# xled_ctrl

- Memory-mapped LED controller and bus responder for the `led_sel` select produced by the address decoder.
- Holds a static LED pattern plus an optional hardware blink engine, and drives the board LED pins.
- Writes are accepted in the cycle they are presented; read data is registered and feeds the decoder's read-data mux.

## Interface

Parameters:
- `N_LEDS`, 8: number of LED outputs, 1..32.
- `DATA_W`, 32: bus data width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sel`  in  1  block select (`led_sel` from decoder).
- `we`  in  1  write enable, qualified by `sel`.
- `addr`  in  2  word offset within block.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data.
- `led`  out  N_LEDS  LED pin drive, registered.

## Operation

Register map (word offsets):
- 0 `LED_OUT`, RW: static pattern in `[N_LEDS-1:0]`.
- 1 `BLINK_MASK`, RW: 1 = that LED toggles with blink phase.
- 2 `PERIOD`, RW, 32-bit: half-period in clock cycles. 0 = blinking stopped.
- 3 `STATUS`, RO: bit0 = current phase. Writes ignored.

Bus behaviour:
- Write: `sel & we` updates the addressed register at the rising edge.
- Read: `sel & ~we` loads `data_out` with the addressed register at the rising edge. Values narrower than DATA_W are zero-extended.
- Idle: when `sel` is low, `data_out` holds its last value.
- Width rule: writes to `LED_OUT`/`BLINK_MASK` take `data_in[N_LEDS-1:0]`; upper bits are discarded and read back as 0.

Blink engine:
- States: STOP (`PERIOD==0`) and RUN (`PERIOD!=0`).
- STOP: counter held 0, phase held 0.
- RUN: counter increments every cycle. When counter == `PERIOD-1`, counter goes to 0 and phase toggles, giving a toggle every `PERIOD` cycles.
- Output: `led <= LED_OUT ^ (BLINK_MASK & {N_LEDS{phase}})`, registered every cycle.

Boundary cases:
- Writing `PERIOD` (any value) clears counter to 0; phase is unchanged. This write overrides a terminal-count event in the same cycle (no toggle that cycle).
- Writing `PERIOD=0` forces phase to 0 on the next edge.
- `PERIOD=1`: phase toggles every cycle.
- Counter is 32 bits; `PERIOD=0xFFFFFFFF` must not overflow.
- Read and terminal count in the same cycle: `STATUS` read returns the pre-toggle phase.

Reset (`rst_n` low, any time, including mid-blink):
- `LED_OUT`, `BLINK_MASK`, `PERIOD`, counter, phase, `data_out` and `led` all go to 0 immediately.

## Timing

- Write-to-LED latency: a write at edge k updates the register; `led` reflects it at edge k+1.
- Read latency: 1 cycle. Address presented in cycle k; `data_out` is valid after edge k and held until the next read.
- No wait states and no backpressure; every selected access completes in one cycle.
- Blink toggle: the phase change appears on `led` one cycle after the phase register flips.
- Reset release is synchronous to the first `clk` edge with `rst_n` high. No access is required in that cycle.

## Configuration

Macro `LED_BLINK_EN`:
- Defined: blink engine, `BLINK_MASK`, `PERIOD` and `STATUS` are present as described above.
- Undefined:
  - Counter, phase, `BLINK_MASK` and `PERIOD` are not instantiated.
  - Offsets 1–3 read 0 and writes to them are ignored.
  - `led <= LED_OUT` with the same 1-cycle latency.

## Test plan

- Reset then idle: drive `rst_n` low mid-blink with `PERIOD=4`. All outputs must be 0 while reset is low and stay 0 after release until a write.
- Static pattern: write `LED_OUT=0xA5`. `led=0xA5` one cycle later. Reading offset 0 returns `0x000000A5` one cycle after the access. Writing `0xFFFFFF3C` reads back `0x3C` (N_LEDS=8).
- Blink: `LED_OUT=0x0F`, `BLINK_MASK=0xFF`, `PERIOD=3`. `led` alternates `0x0F`/`0xF0` every 3 cycles. `STATUS` bit0 tracks phase.
- PERIOD rewrite at terminal count: write `PERIOD=5` exactly in the terminal cycle. Expect no toggle that cycle and the next toggle 5 cycles later.
- Stop: write `PERIOD=0` while phase=1. Phase and blinking LEDs return to the static pattern within 2 cycles and stay there.
- Build without `LED_BLINK_EN`: writes to offsets 1–3 have no effect, reads return 0, and `led` follows `LED_OUT` only.
